// File: rtl/mux_sched_pkg.sv
// Shared definitions for the round-robin mux scheduler: state encoding, size defaults
// and the one-hot-to-index helper. Optional feature macro: MUX_SCHED_PRIO0_EN.
package mux_sched_pkg;

    localparam int N_REQ_DEF = 8;
    localparam int SEL_W_DEF = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [SEL_W_DEF-1:0] onehot_to_idx(input logic [N_REQ_DEF-1:0] oh);
        logic [SEL_W_DEF-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ_DEF; i++) begin
            if (oh[i]) begin
                idx = idx | SEL_W_DEF'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_8x1.sv
// Single-bit 8:1 multiplexer shared by the eight requesters; {s2,s1,s0} selects the d-input.
module mux_8x1 (
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic d4,
    input  logic d5,
    input  logic d6,
    input  logic d7,
    input  logic s0,
    input  logic s1,
    input  logic s2,
    output logic out
);

    always_comb begin
        out = d0;
        case ({s2, s1, s0})
            3'd0:    out = d0;
            3'd1:    out = d1;
            3'd2:    out = d2;
            3'd3:    out = d3;
            3'd4:    out = d4;
            3'd5:    out = d5;
            3'd6:    out = d6;
            default: out = d7;
        endcase
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: scans ptr+1, ptr+2, ... modulo N_REQ,
// with ptr itself checked last, and reports the first requesting index.
module rr_pick
    import mux_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner scheduler for the shared 8:1 mux with a per-grant dwell cap.
// Defining MUX_SCHED_PRIO0_EN makes requester 0 preempt any other owner.
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int SEL_W       = SEL_W_DEF,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             switch
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             busy_q, busy_d;
    logic             switch_q, switch_d;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             win_found;
    logic [SEL_W-1:0] win_idx;
    logic [SEL_W-1:0] owner;
    logic             preempt;
    logic             release_now;

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner = onehot_to_idx(grant_q);

`ifdef MUX_SCHED_PRIO0_EN
    // Requester 0 wins every decision it takes part in and can cut any other owner short.
    assign win_found = pick_found;
    assign win_idx   = req[0] ? '0 : pick_idx;
    assign preempt   = (state_q == ST_GRANT) && req[0] && (owner != '0);
`else
    assign win_found = pick_found;
    assign win_idx   = pick_idx;
    assign preempt   = 1'b0;
`endif

    assign release_now = (state_q == ST_GRANT) &&
                         (!req[owner] || (cnt_q == CNT_W'(HOLD_CYCLES - 1)) || preempt);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        grant_d  = grant_q;
        busy_d   = busy_q;
        switch_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d  = ST_GRANT;
                    ptr_d    = win_idx;
                    cnt_d    = '0;
                    sel_d    = win_idx;
                    grant_d  = N_REQ'(1) << win_idx;
                    busy_d   = 1'b1;
                    switch_d = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!release_now) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (win_found) begin
                    // Hand over on the same edge; re-granting the same owner just restarts the dwell.
                    ptr_d    = win_idx;
                    cnt_d    = '0;
                    sel_d    = win_idx;
                    grant_d  = N_REQ'(1) << win_idx;
                    switch_d = (win_idx != owner);
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ptr resets to the last index so the first search after reset starts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= SEL_W'(N_REQ - 1);
            cnt_q    <= '0;
            sel_q    <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            switch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            switch_q <= switch_d;
        end
    end

    assign sel    = sel_q;
    assign grant  = grant_q;
    assign busy   = busy_q;
    assign switch = switch_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Scoreboard bench for mux_rr_scheduler driving a shared mux_8x1; expected outputs come
// from a behavioural owner/ptr/hold-count model and are checked one cycle after issue.
module tb_mux_rr_scheduler;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       busy;
    logic       switch;
    logic [7:0] d_vec;
    logic       mux_out;

    typedef struct {
        logic [7:0] grant;
        logic [2:0] sel;
        logic       busy;
        logic       sw;
        logic       out;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state: owner (-1 = idle), last owner pointer, cycles held, select.
    int       m_owner;
    int       m_ptr;
    int       m_held;
    int       m_sel;
    bit       m_prio;

    mux_rr_scheduler #(
        .N_REQ       (8),
        .SEL_W       (3),
        .HOLD_CYCLES (HOLD),
        .CNT_W       (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .sel    (sel),
        .grant  (grant),
        .busy   (busy),
        .switch (switch)
    );

    mux_8x1 u_mux (
        .d0  (d_vec[0]),
        .d1  (d_vec[1]),
        .d2  (d_vec[2]),
        .d3  (d_vec[3]),
        .d4  (d_vec[4]),
        .d5  (d_vec[5]),
        .d6  (d_vec[6]),
        .d7  (d_vec[7]),
        .s0  (sel[0]),
        .s1  (sel[1]),
        .s2  (sel[2]),
        .out (mux_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_step(input logic r, input logic [7:0] rq, output exp_t e);
        bit need;
        int win;
        bit sw;
        sw = 1'b0;
        if (r) begin
            m_owner = -1;
            m_ptr   = 7;
            m_held  = 0;
            m_sel   = 0;
        end else begin
            if (m_owner < 0)                               need = 1'b1;
            else if (rq[m_owner] == 1'b0)                  need = 1'b1;
            else if (m_held == HOLD)                       need = 1'b1;
            else if (m_prio && rq[0] && m_owner != 0)      need = 1'b1;
            else                                           need = 1'b0;
            if (!need) begin
                m_held++;
            end else if (rq == 8'h00) begin
                m_owner = -1;
                m_held  = 0;
            end else begin
                win = -1;
                if (m_prio && rq[0]) win = 0;
                for (int i = 1; i <= 8 && win < 0; i++) begin
                    if (rq[(m_ptr + i) % 8]) win = (m_ptr + i) % 8;
                end
                sw      = (win != m_owner);
                m_owner = win;
                m_ptr   = win;
                m_held  = 1;
                m_sel   = win;
            end
        end
        e.grant = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        e.sel   = 3'(m_sel);
        e.busy  = (m_owner >= 0);
        e.sw    = sw;
        e.out   = d_vec[m_sel];
    endtask

    task automatic drive(input logic r, input logic [7:0] rq);
        exp_t e;
        rst   = r;
        req   = rq;
        d_vec = 8'($urandom);
        model_step(r, rq, e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
        end
    endtask

    // Monitor: one output set per clock, compared against the oldest queued expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("grant",  grant,          e.grant);
            cmp("sel",    {5'd0, sel},    {5'd0, e.sel});
            cmp("busy",   {7'd0, busy},   {7'd0, e.busy});
            cmp("switch", {7'd0, switch}, {7'd0, e.sw});
            cmp("mux_out", {7'd0, mux_out}, {7'd0, e.out});
        end
    end

    initial begin
        logic [7:0] rq;
        m_owner = -1;
        m_ptr   = 7;
        m_held  = 0;
        m_sel   = 0;
`ifdef MUX_SCHED_PRIO0_EN
        m_prio = 1'b1;
`else
        m_prio = 1'b0;
`endif
        rst   = 1'b1;
        req   = 8'h00;
        d_vec = 8'h00;

        drive(1'b1, 8'h00);
        drive(1'b1, 8'h00);
        for (int i = 0; i < 5; i++) drive(1'b0, 8'h00);
        for (int i = 0; i < 12; i++) drive(1'b0, 8'h22);
        drive(1'b1, 8'h00);
        for (int i = 0; i < 10; i++) drive(1'b0, 8'h81);
        drive(1'b0, 8'h00);
        for (int i = 0; i < 2; i++) drive(1'b0, 8'h08);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h40);
        for (int i = 0; i < 12; i++) drive(1'b0, 8'h10);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h20);
        drive(1'b1, 8'h20);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h21);
        drive(1'b0, 8'h00);
        for (int i = 0; i < 2; i++) drive(1'b0, 8'h20);
        for (int i = 0; i < 6; i++) drive(1'b0, 8'h21);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       rq = 8'h00;
                1:       rq = 8'(1 << $urandom_range(0, 7));
                2:       rq = 8'($urandom) & 8'($urandom);
                default: rq = 8'($urandom);
            endcase
            drive(($urandom_range(0, 63) == 0), rq);
            if ($urandom_range(0, 3) != 0) begin
                drive(1'b0, rq);
            end
        end

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
- Round-robin scheduler that shares the 8:1 mux datapath (mux_8x1) between 8 requesters.
- Drives the mux select lines: sel[0]→s0, sel[1]→s1, sel[2]→s2.
- Caps each requester's ownership at HOLD_CYCLES consecutive cycles.
- Provides a one-hot grant vector so each source knows when its d-input is routed to out.

Parameters:
- N_REQ, 8, number of requesters; fixed to 8 to match mux_8x1.
- SEL_W, 3, select width, log2(N_REQ).
- HOLD_CYCLES, 4, maximum consecutive cycles per grant; legal range 1..15.
- CNT_W, 4, dwell counter width.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  8  request vector; bit k = source k wants the mux.
- sel  out 3  mux select {s2,s1,s0} = index of current/last owner.
- grant  out  8  one-hot owner; all zero when idle.
- busy  out  1  1 while any grant is active.
- switch  out  1  one-cycle pulse on the first cycle of a grant to a new owner.

Behaviour:
- All outputs are registered. Reset values:
  - sel=3'b000, grant=8'h00, busy=0, switch=0.
  - state=IDLE, last-owner pointer ptr=7, dwell counter cnt=0.
- Winner search:
  - Scan indices ptr+1, ptr+2, … modulo 8, wrapping 7→0.
  - The first set req bit wins. ptr itself is scanned last.
- State IDLE:
  - If req≠0, next edge: state=GRANT, grant=onehot(k), sel=k, busy=1, ptr=k, cnt=0, switch=1.
  - Latency is one clock from req sampled to grant visible.
- State GRANT, owner k:
  - Each cycle cnt increments.
  - Release condition: req[k]==0, or cnt==HOLD_CYCLES-1 (owner has held HOLD_CYCLES cycles).
  - If both release causes occur in the same cycle, treat it as a single release.
- On release:
  - If any req is set, re-run the winner search from ptr+1 and hand over on the same edge (no idle gap). Load cnt=0.
  - If the winner differs from k, switch=1.
  - If the winner is k (only requester left), grant stays asserted, cnt restarts, switch=0.
  - If req==0, next edge: state=IDLE, grant=0, busy=0, switch=0.
- sel holds its last value while IDLE so the mux output stays defined. sel never changes without a grant change.
- Requests not granted are never dropped or latched; the scheduler re-samples req every cycle.
- HOLD_CYCLES=1: ownership rotates every cycle among active requesters.
- rst asserted mid-grant: at the next edge all outputs and state take reset values regardless of req. The first grant after reset searches from index 0.

Optional Feature:
- Macro: MUX_SCHED_PRIO0_EN.
- When defined:
  - req[0] preempts. If req[0]=1 while the owner is not 0, the next edge grants 0 (sel=000, switch=1, cnt=0, ptr=0), ignoring the current owner's cnt.
  - Owner 0 is still limited by HOLD_CYCLES.
  - If req[0] stays high after owner 0 releases, the next winner is still 0. Requester 0 can therefore hold the mux continuously while req[0] is asserted.
- When undefined: pure round-robin, and req[0] has no special treatment.

Decomposition:
- Shared package mux_sched_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1;
  - N_REQ and SEL_W defaults;
  - the onehot-to-index helper function.
- One sub-module, rr_pick: purely combinational rotating priority encoder.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: found, idx[2:0].
- mux_rr_scheduler holds the FSM, counter and output registers. The bench instantiates it alongside mux_8x1.

Test Plan:
1. After rst, req=8'h00 for 5 cycles → grant=8'h00, sel=000, busy=0, switch never asserted.
2. req=8'b0010_0010 held, HOLD=4 → grant 8'h02 (sel=001) for 4 cycles, then 8'h20 (sel=101) for 4 cycles, then 8'h02 again; switch pulses at each change; mux out equals d1, then d5.
3. Wrap: req=8'b1000_0001 held → grant 8'h01 first (ptr=7 after reset), then 8'h80, then 8'h01; sel sequence 000, 111, 000.
4. Early release: owner 3 (sel=011), req[3] drops after 2 grant cycles with req[6]=1 → next edge grant=8'h40, sel=110, switch=1 for one cycle.
5. Single requester req=8'h10 held 12 cycles → grant stays 8'h10, sel=100, busy=1 throughout, switch=1 only on first cycle. Then req=0 → next edge grant=0, busy=0, sel stays 100.
6. rst asserted while owner 5 at cnt=2 → next edge grant=0, sel=000, busy=0. With req=8'h21 afterward → grant 8'h01 first. With MUX_SCHED_PRIO0_EN, owner 5 + req[0] rising → next edge grant=8'h01.
